led_pwm_sequencer: RTL and testbench
====================================

Name: led_pwm_sequencer

Overview:
Command-driven brightness controller for the 10-level LED PWM (duty 0..9). Accepts intensity commands from the slave-side command decoder through a valid/ready handshake and buffers them in a small FIFO. Each command is applied either immediately or as a fade of one level per STEP_PERIODS PWM periods. The block drives the PWM generator's duty input and uses the generator's period-wrap pulse as its fade timebase.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2
STEP_PERIODS, 8, PWM periods per fade step; minimum 1
MAX_LEVEL, 9, highest legal duty level

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept; equals !fifo_full
cmd_level  in  4  target duty level
cmd_fade  in  1  1 = ramp to target, 0 = jump to target
abort  in  1  flush FIFO, freeze duty at its current value
period_tick  in  1  one-cycle pulse at each PWM counter wrap (9 -> 0)
duty_level  out  4  duty to PWM generator, always 0..MAX_LEVEL
busy  out  1  state != IDLE or FIFO non-empty
clamp_err  out  1  one-cycle pulse when an accepted cmd_level exceeds MAX_LEVEL

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty; state IDLE; target = 0; step_cnt = 0.
  - Outputs: duty_level = 0, busy = 0, clamp_err = 0, cmd_ready = 1.
- Push: occurs when cmd_valid && cmd_ready at a rising edge.
  - {clamped level, fade} is written to the FIFO.
  - cmd_level > MAX_LEVEL is stored as MAX_LEVEL, and clamp_err is high for the following cycle.
- FSM states IDLE, LOAD, FADE:
  - IDLE: if the FIFO is non-empty, pop the head into target/fade_r and go to LOAD. Otherwise stay.
  - LOAD:
    - target == duty_level: go to IDLE, no change.
    - fade_r = 0: duty_level <= target, go to IDLE.
    - fade_r = 1: step_cnt <= 0, go to FADE.
  - FADE, on period_tick only:
    - If step_cnt == STEP_PERIODS-1: step_cnt <= 0 and duty_level moves one toward target. If the new value equals target, go to IDLE.
    - Otherwise step_cnt increments.
    - With no period_tick, FADE holds.
- Latency:
  - Immediate command pushed at edge N appears on duty_level after edge N+2 (pop at N+1, apply at N+2).
  - A fade of distance D completes after exactly D*STEP_PERIODS period_ticks counted from entering FADE.
- duty_level changes in FADE only on a period_tick edge. It therefore never changes mid-PWM-period during a fade.
- Pop and push in the same cycle are both allowed. FIFO count is unchanged and ordering is preserved.
- Full FIFO: cmd_ready = 0. A cmd_valid held high is not accepted, and no data is lost or overwritten.
- Empty FIFO in IDLE: no pop and no state change.
- abort (synchronous, highest priority):
  - Next edge empties the FIFO, sets state to IDLE and step_cnt to 0, and holds duty_level at its current value.
  - A push in the same cycle is discarded and clamp_err stays 0.
- period_tick is ignored outside FADE.
- Back-to-back commands: a new command is popped on the first IDLE cycle after the previous one completes. The next fade starts from the current duty_level.
- Reset asserted mid-fade: all outputs return to reset values immediately, without a clock.

Decomposition:
- Package led_pwm_pkg holds:
  - LEVEL_W = 4, MAX_LEVEL = 9
  - typedef level_t (logic [3:0])
  - typedef struct packed {level_t level; logic fade;} led_cmd_t
  - enum seq_state_t {IDLE, LOAD, FADE}
- Sub-module led_cmd_fifo: synchronous FIFO of led_cmd_t with push, pop, flush, full, empty and head outputs, parameterised by depth.
- The sequencer instantiates the FIFO and contains the FSM, the step counter and the clamp logic.

Test Plan:
- Reset, then push level=5 with fade=0 at edge N -> duty_level = 5 after edge N+2; busy high on cycles N+1..N+2, then low.
- From duty 2, push level=6 with fade=1, STEP_PERIODS=8, period_tick every 10 clk -> duty steps 3,4,5,6, one step per 8 ticks; 32 ticks in total; busy drops after reaching 6.
- Push level=12 with fade=0 -> clamp_err pulses for 1 cycle; duty_level = 9, never above 9.
- Hold cmd_valid with FIFO_DEPTH=4 and no pops (mid-fade) -> cmd_ready drops after 4 accepts; the 5th command is accepted only after a pop; commands execute in FIFO order.
- Fade 0 -> 9 with abort at duty=4 plus simultaneous cmd_valid -> duty stays 4, FIFO empty, busy=0, pushed command dropped.
- Assert rst_n low mid-fade at duty 7, asynchronously between edges -> duty_level = 0 and busy = 0 immediately; after release, cmd_ready = 1.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared types and constants for the LED PWM brightness sequencer.
// Levels, queued commands and sequencer states.
package led_pwm_pkg;

    localparam int LEVEL_W   = 4;
    localparam int MAX_LEVEL = 9;

    typedef logic [LEVEL_W-1:0] level_t;

    typedef struct packed {
        level_t level;
        logic   fade;
    } led_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FADE
    } seq_state_t;

endpackage

// File: rtl/led_cmd_fifo.sv
// Small synchronous command FIFO with flush.
// Head is combinational from the read pointer.
module led_cmd_fifo
    import led_pwm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  logic     flush,
    input  led_cmd_t din,
    output led_cmd_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    led_cmd_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           wr_en;
    logic           rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && !full && !flush;
    assign rd_en = pop && !empty && !flush;
    assign head  = mem[rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/led_pwm_sequencer.sv
// Command-driven brightness sequencer for the 10-level LED PWM.
// Applies queued levels immediately or as a tick-paced fade.
module led_pwm_sequencer
    import led_pwm_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STEP_PERIODS = 8,
    parameter int MAX_LEVEL    = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_level,
    input  logic         cmd_fade,
    input  logic         abort,
    input  logic         period_tick,
    output logic [3:0]   duty_level,
    output logic         busy,
    output logic         clamp_err
);

    localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam level_t MAXL = level_t'(MAX_LEVEL);

    seq_state_t     state_q, state_n;
    level_t         duty_q, duty_n;
    level_t         target_q, target_n;
    logic           fade_q, fade_n;
    logic [SW-1:0]  step_q, step_n;
    logic           clamp_q;

    led_cmd_t       cmd_in;
    led_cmd_t       head;
    logic           full, empty;
    logic           push, pop;
    logic           over;
    level_t         duty_step;

    assign over      = (cmd_level > MAXL);
    assign cmd_in    = '{level: (over ? MAXL : cmd_level), fade: cmd_fade};
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready && !abort;
    assign pop       = (state_q == IDLE) && !empty && !abort;
    assign duty_step = (duty_q < target_q) ? duty_q + 1'b1 : duty_q - 1'b1;

    assign duty_level = duty_q;
    assign busy       = (state_q != IDLE) || !empty;
    assign clamp_err  = clamp_q;

    led_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (abort),
        .din   (cmd_in),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Next-state: pop, apply or fade; abort freezes duty and idles.
    always_comb begin
        state_n  = state_q;
        duty_n   = duty_q;
        target_n = target_q;
        fade_n   = fade_q;
        step_n   = step_q;
        if (abort) begin
            state_n = IDLE;
            step_n  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!empty) begin
                        target_n = head.level;
                        fade_n   = head.fade;
                        state_n  = LOAD;
                    end
                end
                LOAD: begin
                    if (target_q == duty_q) begin
                        state_n = IDLE;
                    end else if (!fade_q) begin
                        duty_n  = target_q;
                        state_n = IDLE;
                    end else begin
                        step_n  = '0;
                        state_n = FADE;
                    end
                end
                FADE: begin
                    if (period_tick) begin
                        if (step_q == SW'(STEP_PERIODS-1)) begin
                            step_n = '0;
                            duty_n = duty_step;
                            if (duty_step == target_q) state_n = IDLE;
                        end else begin
                            step_n = step_q + 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Sequencer registers and the one-cycle clamp flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            target_q <= '0;
            fade_q   <= 1'b0;
            step_q   <= '0;
            clamp_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            duty_q   <= duty_n;
            target_q <= target_n;
            fade_q   <= fade_n;
            step_q   <= step_n;
            clamp_q  <= push && over;
        end
    end

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Self-checking bench for led_pwm_sequencer.
// Scoreboard of expected duty values plus direct timing checks.
module tb_led_pwm_sequencer;
    import led_pwm_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_level;
    logic       cmd_fade;
    logic       abort;
    logic       period_tick;
    logic [3:0] duty_level;
    logic       busy;
    logic       clamp_err;

    int         nchk;
    int         nerr;
    level_t     exp_q[$];
    int         cur;
    logic [3:0] prev;

    led_pwm_sequencer #(
        .FIFO_DEPTH   (4),
        .STEP_PERIODS (8),
        .MAX_LEVEL    (9)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_level   (cmd_level),
        .cmd_fade    (cmd_fade),
        .abort       (abort),
        .period_tick (period_tick),
        .duty_level  (duty_level),
        .busy        (busy),
        .clamp_err   (clamp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        nchk++;
        if (obs !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Bench model: expected duty trajectory for an accepted command.
    task automatic model(input int lvl, input bit fade);
        int t;
        t = (lvl > 9) ? 9 : lvl;
        if (t != cur) begin
            if (fade) begin
                while (cur != t) begin
                    cur = (t > cur) ? cur + 1 : cur - 1;
                    exp_q.push_back(level_t'(cur));
                end
            end else begin
                exp_q.push_back(level_t'(t));
                cur = t;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int lvl, input bit fade);
        int n;
        n = 0;
        cmd_level = 4'(lvl);
        cmd_fade  = fade;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) begin
            chk("send_timeout", 0, 1);
        end else begin
            step();
            model(lvl, fade);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic tick();
        period_tick = 1'b1;
        step();
        period_tick = 1'b0;
        repeat (9) step();
    endtask

    // Duty monitor: every change must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev = 4'd0;
        end else if (duty_level !== prev) begin
            chk("duty_range", 32'(duty_level <= 4'd9), 1);
            if (exp_q.size() == 0) chk("sb_extra", duty_level, prev);
            else chk("sb_duty", duty_level, exp_q.pop_front());
            prev = duty_level;
        end
    end

    initial begin
        int k;
        nchk = 0;
        nerr = 0;
        cur  = 0;
        prev = 4'd0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_level = 4'd0;
        cmd_fade = 1'b0;
        abort = 1'b0;
        period_tick = 1'b0;

        #1;
        chk("rst_duty", duty_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clamp", clamp_err, 0);
        chk("rst_ready", cmd_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Immediate command: visible after second edge.
        cmd_level = 4'd5;
        cmd_fade  = 1'b0;
        cmd_valid = 1'b1;
        step();
        model(5, 0);
        cmd_valid = 1'b0;
        chk("imm_busy_n1", busy, 1);
        chk("imm_duty_n1", duty_level, 0);
        step();
        chk("imm_busy_n2", busy, 1);
        chk("imm_duty_n2", duty_level, 0);
        step();
        chk("imm_duty", duty_level, 5);
        chk("imm_idle", busy, 0);

        // Fade 2 -> 6 paced by ticks.
        send(2, 0);
        repeat (3) step();
        chk("pre_fade", duty_level, 2);
        send(6, 1);
        repeat (2) step();
        k = 0;
        while (duty_level != 4'd6 && k < 100) begin
            tick();
            k++;
            if (k == 7) chk("fade_hold", duty_level, 2);
            if (k % 8 == 0) chk("fade_step", duty_level, 32'(2 + k / 8));
        end
        chk("fade_ticks", k, 32);
        chk("fade_idle", busy, 0);

        // Out-of-range level is clamped.
        send(12, 0);
        chk("clamp_pulse", clamp_err, 1);
        step();
        chk("clamp_drop", clamp_err, 0);
        step();
        chk("clamp_duty", duty_level, 9);

        // Fill the FIFO while a fade blocks pops.
        send(8, 1);
        repeat (2) step();
        cmd_valid = 1'b1;
        cmd_fade  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cmd_level = 4'(i);
            step();
            model(i, 0);
        end
        chk("full_ready", cmd_ready, 0);
        chk("full_busy", busy, 1);
        cmd_level = 4'd5;
        repeat (3) step();
        chk("full_hold", cmd_ready, 0);
        repeat (7) tick();
        period_tick = 1'b1;
        step();
        period_tick = 1'b0;
        chk("full_fade_done", duty_level, 8);
        chk("full_no_pop", cmd_ready, 0);
        step();
        chk("pop_ready", cmd_ready, 1);
        step();
        model(5, 0);
        cmd_valid = 1'b0;
        chk("refill_ready", cmd_ready, 0);
        repeat (20) step();
        chk("order_duty", duty_level, 5);
        chk("order_idle", busy, 0);

        // Abort mid-fade with a queued command and a push.
        send(0, 0);
        repeat (4) step();
        send(9, 1);
        step();
        send(3, 0);
        k = 0;
        while (duty_level != 4'd4 && k < 100) begin
            tick();
            k++;
        end
        chk("abort_reach", duty_level, 4);
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_level = 4'd12;
        cmd_fade  = 1'b0;
        exp_q.delete();
        cur = 4;
        step();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        chk("abort_duty", duty_level, 4);
        chk("abort_busy", busy, 0);
        chk("abort_clamp", clamp_err, 0);
        chk("abort_ready", cmd_ready, 1);
        repeat (8) tick();
        chk("abort_frozen", duty_level, 4);
        chk("abort_still", busy, 0);

        // Asynchronous reset mid-fade.
        send(9, 1);
        step();
        k = 0;
        while (duty_level != 4'd7 && k < 100) begin
            tick();
            k++;
        end
        chk("rstmid_reach", duty_level, 7);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        cur = 0;
        #1;
        chk("rstmid_duty", duty_level, 0);
        chk("rstmid_busy", busy, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rstmid_ready", cmd_ready, 1);
        chk("rstmid_hold", duty_level, 0);
        send(3, 0);
        repeat (3) step();
        chk("post_rst_duty", duty_level, 3);
        step();
        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
